cim_weight_loader: RTL

Upstream stage of the CIM array write path. Accepts a byte stream of weights over a valid/ready handshake and packs every 3 bytes into one 24-bit row word. It then issues one registered write per row: data, write address and bank select (cima) go to the array controller, which routes the address to bank0 or bank1. A start/busy/done command interface sequences a burst of rows from a base address.

---
 rtl/cim_weight_loader_pkg.sv | 9 +
 rtl/cim_weight_loader_if.sv | 13 +
 rtl/cim_byte_packer.sv | 35 +++
 rtl/cim_weight_loader.sv | 95 +++++++++
 4 files changed

// File: rtl/cim_weight_loader_pkg.sv
// cim_pkg: shared widths and FSM states for the CIM weight loader
package cim_pkg;
    localparam int DATA_W        = 24;
    localparam int ADDR_W        = 8;
    localparam int BYTE_W        = 8;
    localparam int BYTES_PER_ROW = DATA_W / BYTE_W;
    localparam int LANE_W        = 2;
    typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_t;
endpackage

// File: rtl/cim_weight_loader_if.sv
// cim_weight_loader_if: byte stream in, row write bus out to the array controller
interface cim_weight_loader_if;
    import cim_pkg::*;
    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] D;
    logic [ADDR_W-1:0] WA;
    logic              cima;
    logic              wr_en;
    modport master (output in_data, in_valid, input in_ready, D, WA, cima, wr_en);
    modport slave  (input in_data, in_valid, output in_ready, D, WA, cima, wr_en);
endinterface

// File: rtl/cim_byte_packer.sv
// cim_byte_packer: assembles BYTES_PER_ROW bytes, little-endian by lane, into one row word
module cim_byte_packer
    import cim_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              accept,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [DATA_W-1:0] word,
    output logic              word_full
);
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              last;

    always_comb begin
        last   = lane_q == LANE_W'(BYTES_PER_ROW - 1);
        word_d = word_q;
        if (accept) word_d[int'(lane_q)*BYTE_W +: BYTE_W] = byte_in;
        lane_d    = clr ? '0 : accept ? (last ? '0 : lane_q + LANE_W'(1)) : lane_q;
        word_full = accept && last;
        word      = word_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            word_q <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= clr ? '0 : word_d;
        end
    end
endmodule

// File: rtl/cim_weight_loader.sv
// cim_weight_loader: packs a weight byte stream into row words and issues one
// registered array write per row over a start/busy/done burst
module cim_weight_loader
    import cim_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_rows,
    input  logic              bank_sel,
    cim_weight_loader_if.slave bus,
    output logic              busy,
    output logic              done
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, wa_q, wa_d;
    logic [ADDR_W:0]   rows_q, rows_d;
    logic              bank_q, bank_d, cima_q, cima_d;
    logic [DATA_W-1:0] d_q, d_d, word;
    logic              accept, word_full, in_ready;

    cim_byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state_q != PACK),
        .accept    (accept),
        .byte_in   (bus.in_data),
        .word      (word),
        .word_full (word_full)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rows_d   = rows_q;
        bank_d   = bank_q;
        d_d      = d_q;
        wa_d     = wa_q;
        cima_d   = cima_q;
        in_ready = state_q == PACK && !abort;
        accept   = bus.in_valid && in_ready;
        case (state_q)
            IDLE: if (start) begin
                addr_d  = base_addr;
                rows_d  = num_rows;
                bank_d  = bank_sel;
                state_d = num_rows == '0 ? DONE : PACK;
            end
            PACK: if (word_full) begin
                d_d     = word;
                wa_d    = addr_q;
                cima_d  = bank_q;
                state_d = WRITE;
            end
            WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                rows_d  = rows_q - (ADDR_W+1)'(1);
                state_d = rows_q == (ADDR_W+1)'(1) ? DONE : PACK;
            end
            default: state_d = IDLE;
        endcase
        // abort wins over every other transition and drops any partial word
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rows_q  <= '0;
            bank_q  <= 1'b0;
            d_q     <= '0;
            wa_q    <= '0;
            cima_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rows_q  <= rows_d;
            bank_q  <= bank_d;
            d_q     <= d_d;
            wa_q    <= wa_d;
            cima_q  <= cima_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.D        = d_q;
    assign bus.WA       = wa_q;
    assign bus.cima     = cima_q;
    assign bus.wr_en    = state_q == WRITE;
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
endmodule
